bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the two-digit seven-segment hex/decimal display driver. It takes an 8-bit binary value such as a score, count or timer from game logic, converts it over BIN_W cycles, and presents packed BCD. The low byte `bcd_out[7:0]` feeds the display driver's 8-bit input directly, so no decimal fix-up is needed downstream.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W - 1.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request to convert `bin_in`.
- in_ready  out  1  block can accept a new value this cycle.
- bin_in  in  BIN_W  binary value; sampled only on accept.
- out_valid  out  1  `bcd_out` holds a completed conversion.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0].
- ovf2  out  1  result exceeds 99: any digit above digit 1 is nonzero; qualified by `out_valid`.

Behaviour:
- Reset (Reset_n low, async, at any time including mid-conversion):
  - state = IDLE, shift register = 0, bit counter = 0.
  - in_ready = 1, out_valid = 0, bcd_out = 0, ovf2 = 0.
  - A conversion in flight is discarded.
- States: IDLE, SHIFT, DONE.
  - `in_ready` = 1 in IDLE and DONE, 0 in SHIFT. It is a combinational decode of the state.
- Accept: rising edge with in_valid && in_ready.
  - Load bin_in into the binary part of the working register and clear the BCD part.
  - counter = 0; state goes to SHIFT; out_valid clears on the same edge.
- SHIFT, each cycle:
  - Every 4-bit BCD digit >= 5 gets +3 (all digits adjusted in parallel from pre-shift values).
  - Then the whole {bcd, bin} register shifts left by 1.
  - counter increments.
  - On the cycle where counter == BIN_W-1, the shift completes and the edge moves to DONE.
  - That same edge registers bcd_out, sets out_valid = 1 and registers ovf2.
- Latency: accept on edge k gives out_valid = 1 after edge k+BIN_W (8 cycles at default).
  - Throughput is one conversion per BIN_W+1 cycles, counting the accept cycle.
- DONE:
  - out_valid and bcd_out hold indefinitely.
  - A new accept in DONE behaves as from IDLE; out_valid drops after that edge.
- in_valid while in SHIFT is ignored; no queueing. The source must hold in_valid until it sees in_ready.
- bcd_out changes only on the completing edge or on reset. It never shows partial results.
- Each digit is 0..9 at all times. The add-3 rule guarantees no digit exceeds 9 for BIN_W <= 3.32*DIGITS.
- Counter width is clog2(BIN_W). The counter does not wrap within a conversion.

Decomposition:
- Package `bcd_pkg`:
  - state enum {IDLE, SHIFT, DONE} (2-bit);
  - localparam for counter width;
  - function `digits_for(BIN_W)` for elaboration-time checking of DIGITS.
- Sub-module `bcd_adj3`: 4-bit combinational digit adjust, out = (in >= 5) ? in + 3 : in.
  - Instantiated DIGITS times with a generate loop.
- All other logic (FSM, counter, shift register, output registers) lives in bin_to_bcd_seq.

Test Plan:
- Reset, then accept bin_in=0x00 → out_valid high after 8 edges; bcd_out=0x000, ovf2=0.
- Accept 99 (0x63) → bcd_out=0x099, ovf2=0; the display input byte equals 0x99.
- Accept 255 (0xFF) → bcd_out=0x255, ovf2=1. Then accept 100 (0x64) → bcd_out=0x100, ovf2=1.
- Hold in_valid high with 0x2A through SHIFT, changing bin_in to 0x11 mid-conversion → in_ready=0 for 8 cycles and result is 0x042. A second accept occurs in the DONE cycle, giving 0x017 after 8 more edges with out_valid low in between.
- Assert Reset_n low 3 cycles into converting 0xC8, asynchronously between edges → outputs clear immediately. After release, in_ready=1, out_valid=0, and a new conversion of 0x07 gives 0x007.
- Exhaustive sweep 0..255, back-to-back → every bcd_out matches the reference decimal model, every digit is <= 9, and ovf2 == (value > 99).

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int BIN_W_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    // Bit counter width; a 1-bit binary input still needs a 1-bit counter.
    function automatic int cnt_width(input int bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

    // Smallest digit count d with 10^d > 2^bin_w - 1.
    function automatic int digits_for(input int bin_w);
        longint max_v;
        longint pow10;
        int     d;
        max_v = (longint'(1) << bin_w) - 1;
        pow10 = 10;
        d     = 1;
        while (pow10 <= max_v) begin
            pow10 = pow10 * 10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the value source and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf2;

    // Source side: offers values, observes results.
    modport master (
        output in_valid, bin_in,
        input  in_ready, out_valid, bcd_out, ovf2
    );

    // Converter side.
    modport slave (
        input  in_valid, bin_in,
        output in_ready, out_valid, bcd_out, ovf2
    );
endinterface

// File: rtl/bin_to_bcd_seq_adj3.sv
// Single BCD digit pre-shift correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    // Inputs are at most 9, so +3 never overflows 4 bits.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Results are published only on the completing edge, so bcd_out never shows
// a partial conversion; the low byte drives a two-digit display directly.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    bin_to_bcd_seq_if.slave      bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = cnt_width(BIN_W);

    // Refuse to build a converter whose digits cannot hold the largest input.
    generate
        if (DIGITS < digits_for(BIN_W)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORK_W-1:0]   work_q;     // {bcd digits, remaining binary bits}
    logic [BCD_W-1:0]    bcd_q;
    logic                out_valid_q;
    logic                ovf2_q;

    logic [BCD_W-1:0]    adj_bcd;
    logic [WORK_W-1:0]   work_d;
    logic [BCD_W-1:0]    bcd_d;
    logic                ovf2_d;
    logic                last_shift;
    logic                in_ready;
    logic                accept;

    // All digits are corrected in parallel from their pre-shift values.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_adj3 u_adj (
                .digit_i (work_q[BIN_W + 4*gi +: 4]),
                .digit_o (adj_bcd[4*gi +: 4])
            );
        end
    endgenerate

    // Next working value, the BCD it would publish, and the >99 flag.
    always_comb begin
        work_d     = {adj_bcd, work_q[BIN_W-1:0]} << 1;
        bcd_d      = work_d[WORK_W-1 -: BCD_W];
        ovf2_d     = 1'b0;
        for (int d = 2; d < DIGITS; d++) begin
            ovf2_d = ovf2_d | (|bcd_d[4*d +: 4]);
        end
        last_shift = (cnt_q == CNT_W'(BIN_W - 1));
    end

    assign in_ready = (state_q != SHIFT);
    assign accept   = bus.in_valid && in_ready;

    // Control FSM, shift datapath and registered result outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            ovf2_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        work_q      <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (last_shift) begin
                        state_q     <= DONE;
                        bcd_q       <= bcd_d;
                        ovf2_q      <= ovf2_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.ovf2      = ovf2_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: table vectors, multi-cycle corner
// sequences and an exhaustive back-to-back sweep, with a result scoreboard.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal reference, independent of the shift-and-add algorithm.
    function automatic vec_t ref_model(input int v);
        vec_t r;
        int   d0, d1, d2;
        d0    = v % 10;
        d1    = (v / 10) % 10;
        d2    = v / 100;
        r.bin = 8'(v);
        r.bcd = {4'(d2), 4'(d1), 4'(d0)};
        r.ovf = (v > 99);
        return r;
    endfunction

    // Called near a falling edge while the DUT can accept.
    task automatic do_accept(input vec_t e);
        bus.in_valid = 1'b1;
        bus.bin_in   = e.bin;
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge Clk);
        sb_q.push_back(e);
        @(negedge Clk);
        bus.in_valid = 1'b0;
        check("accept_valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    // Waits (bounded) for out_valid, then pops and compares one result.
    task automatic wait_result(input string tag, input int start_n);
        int          n;
        logic [11:0] hold;
        vec_t        e;
        logic        digits_ok;
        n    = start_n;
        hold = bus.bcd_out;
        while (!bus.out_valid && n < 20) begin
            @(negedge Clk);
            n++;
            if (!bus.out_valid) check({tag, "_bcd_hold"}, 32'(bus.bcd_out), 32'(hold));
        end
        check({tag, "_latency"}, 32'(n), 32'(BIN_W));
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got result, expected none pending", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(e.bcd));
            check({tag, "_ovf2"}, 32'(bus.ovf2), 32'(e.ovf));
            digits_ok = 1'b1;
            for (int d = 0; d < DIGITS; d++)
                if (bus.bcd_out[4*d +: 4] > 4'd9) digits_ok = 1'b0;
            check({tag, "_digits"}, 32'(digits_ok), 32'd1);
            $display("txn %s bin=0x%02h bcd=0x%03h ovf2=%0b (exp 0x%03h/%0b)",
                     tag, e.bin, bus.bcd_out, bus.ovf2, e.bcd, e.ovf);
        end
    endtask

    initial begin
        vec_t e;
        tbl[0] = '{8'h00, 12'h000, 1'b0};
        tbl[1] = '{8'h63, 12'h099, 1'b0};
        tbl[2] = '{8'hFF, 12'h255, 1'b1};
        tbl[3] = '{8'h64, 12'h100, 1'b1};
        tbl[4] = '{8'h09, 12'h009, 1'b0};
        tbl[5] = '{8'h0A, 12'h010, 1'b0};
        tbl[6] = '{8'h80, 12'h128, 1'b1};

        bus.in_valid = 1'b0;
        bus.bin_in   = '0;

        // Reset state
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bcd", 32'(bus.bcd_out), 32'd0);
        check("rst_ovf2", 32'(bus.ovf2), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Table vectors, including 99 -> display byte 0x99 and 255 then 100
        for (int i = 0; i < 7; i++) begin
            do_accept(tbl[i]);
            wait_result($sformatf("tbl%0d", i), 0);
        end
        check("tbl_display_byte", 32'(bus.bcd_out[7:0]), 32'h28);

        // in_valid held through SHIFT with bin_in changing mid-conversion
        bus.in_valid = 1'b1;
        bus.bin_in   = 8'h2A;
        check("hold_accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge Clk);
        sb_q.push_back('{8'h2A, 12'h042, 1'b0});
        for (int c = 0; c < BIN_W; c++) begin
            if (c > 0) @(negedge Clk);
            else       @(negedge Clk);
            check("hold_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid_low", 32'(bus.out_valid), 32'd0);
            if (c == 2) bus.bin_in = 8'h11;
        end
        wait_result("hold", BIN_W - 1);
        check("hold_done_ready", 32'(bus.in_ready), 32'd1);
        @(posedge Clk);
        sb_q.push_back('{8'h11, 12'h017, 1'b0});
        @(negedge Clk);
        bus.in_valid = 1'b0;
        check("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
        wait_result("b2b", 0);

        // Asynchronous reset mid-conversion, with a nonzero result showing
        do_accept(ref_model(255));
        wait_result("prime", 0);
        bus.in_valid = 1'b1;
        bus.bin_in   = 8'hC8;
        @(posedge Clk);
        @(negedge Clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_bcd", 32'(bus.bcd_out), 32'd0);
        check("arst_ovf2", 32'(bus.ovf2), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge Clk);
        do_accept('{8'h07, 12'h007, 1'b0});
        wait_result("post_rst", 0);

        // Exhaustive back-to-back sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            e = ref_model(v);
            do_accept(e);
            wait_result($sformatf("sweep%0d", v), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
